seg_scan_driver: RTL

Parametrised, time-multiplexed 7-segment display driver that replaces the static per-digit decoders and select-driven LED mux. It accepts NUM_DIGITS packed 4-bit values and decodes each to hex. It scans the digits autonomously with a prescaled refresh and drives a shared active-low segment bus plus per-digit anode enables. It adds tear-free shadow loading, anti-ghost guard blanking, per-digit blanking and decimal points, and leading-zero suppression.

---
 rtl/seg_scan_driver.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed hex 7-segment driver: prescaled digit scan, guard blanking,
// tear-free shadow loading, leading-zero suppression. Optional macro: BRIGHTNESS_EN.
module seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 12500,
  parameter int GUARD_CYCLES = 250,
  parameter int CNT_W        = 14
) (
  input  logic                          clk50MHz,
  input  logic                          rst,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         blank_in,
  input  logic                          lz_en,
  input  logic                          load,
`ifdef BRIGHTNESS_EN
  input  logic [2:0]                    bright,
`endif
  output logic [7:0]                    seg_out,
  output logic [NUM_DIGITS-1:0]         an_out,
  output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
  output logic                          frame_done,
  output logic                          load_ack
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Active-high {g,f,e,d,c,b,a} hex glyphs; inverted at the pin stage.
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0: hex_glyph = 7'h3F;
      4'h1: hex_glyph = 7'h06;
      4'h2: hex_glyph = 7'h5B;
      4'h3: hex_glyph = 7'h4F;
      4'h4: hex_glyph = 7'h66;
      4'h5: hex_glyph = 7'h6D;
      4'h6: hex_glyph = 7'h7D;
      4'h7: hex_glyph = 7'h07;
      4'h8: hex_glyph = 7'h7F;
      4'h9: hex_glyph = 7'h6F;
      4'hA: hex_glyph = 7'h77;
      4'hB: hex_glyph = 7'h7C;
      4'hC: hex_glyph = 7'h39;
      4'hD: hex_glyph = 7'h5E;
      4'hE: hex_glyph = 7'h79;
      default: hex_glyph = 7'h71;
    endcase
  endfunction

  logic [CNT_W-1:0]        cnt_p0;
  logic [IDX_W-1:0]        idx_p0;
  logic                    tick, wrap;
  logic [4*NUM_DIGITS-1:0] stage_dig, shadow_dig;
  logic [NUM_DIGITS-1:0]   stage_dp, stage_blank, shadow_dp, shadow_blank;
  logic                    pending;
  logic                    frame_done_p1, load_ack_p1;
  logic [7:0]              seg_p1, seg_nxt;
  logic [NUM_DIGITS-1:0]   an_p1, an_nxt, suppress;
  logic                    zero_run, active;
  logic [3:0]              cur_nib;

  assign tick = (cnt_p0 == CNT_LAST);
  assign wrap = tick && (idx_p0 == IDX_LAST);

  // ---- stage p0: prescaler and digit scan ----
  always_ff @(posedge clk50MHz or negedge rst) begin
    if (!rst) begin
      cnt_p0 <= '0;
      idx_p0 <= '0;
    end else begin
      cnt_p0 <= tick ? '0 : cnt_p0 + 1'b1;
      if (tick) idx_p0 <= wrap ? '0 : idx_p0 + 1'b1;
    end
  end

  // Staging holds the most recent request; only the frame wrap moves it to the shadow.
  always_ff @(posedge clk50MHz) begin
    if (load) begin
      stage_dig   <= digits_in;
      stage_dp    <= dp_in;
      stage_blank <= blank_in;
    end
  end

  always_ff @(posedge clk50MHz or negedge rst) begin
    if (!rst) begin
      shadow_dig    <= '0;
      shadow_dp     <= '0;
      shadow_blank  <= '0;
      pending       <= 1'b0;
      frame_done_p1 <= 1'b0;
      load_ack_p1   <= 1'b0;
    end else begin
      if (wrap && pending) begin
        shadow_dig   <= stage_dig;
        shadow_dp    <= stage_dp;
        shadow_blank <= stage_blank;
      end
      if (load)      pending <= 1'b1;
      else if (wrap) pending <= 1'b0;
      frame_done_p1 <= wrap;
      load_ack_p1   <= wrap && pending;
    end
  end

`ifdef BRIGHTNESS_EN
  localparam int WIN = REFRESH_DIV - GUARD_CYCLES;
  logic [2:0]       bright_q;
  logic [CNT_W+3:0] on_prod, on_len, win_pos;

  always_ff @(posedge clk50MHz or negedge rst) begin
    if (!rst)      bright_q <= 3'd7;
    else if (wrap) bright_q <= bright;
  end

  assign on_prod = (CNT_W+4)'(WIN) * ((CNT_W+4)'(bright_q) + 1'b1);
  assign on_len  = on_prod >> 3;
  assign win_pos = (CNT_W+4)'(cnt_p0) - (CNT_W+4)'(GUARD_CYCLES);
  assign active  = (cnt_p0 >= GUARD_END) && (win_pos < on_len);
`else
  assign active  = (cnt_p0 >= GUARD_END);
`endif

  always_comb begin
    suppress = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run    = zero_run && (shadow_dig[4*k +: 4] == 4'h0);
      suppress[k] = lz_en && zero_run && (k != 0);
    end
    cur_nib = shadow_dig[4*int'(idx_p0) +: 4];
    seg_nxt = 8'hFF;
    an_nxt  = '1;
    if (active) begin
      an_nxt[idx_p0] = 1'b0;
      if (!shadow_blank[idx_p0]) begin
        seg_nxt[7] = ~shadow_dp[idx_p0];
        if (!suppress[idx_p0]) seg_nxt[6:0] = ~hex_glyph(cur_nib);
      end
    end
  end

  // ---- stage p1: registered pins ----
  always_ff @(posedge clk50MHz or negedge rst) begin
    if (!rst) begin
      seg_p1 <= 8'hFF;
      an_p1  <= '1;
    end else begin
      seg_p1 <= seg_nxt;
      an_p1  <= an_nxt;
    end
  end

  assign seg_out    = seg_p1;
  assign an_out     = an_p1;
  assign scan_idx   = idx_p0;
  assign frame_done = frame_done_p1;
  assign load_ack   = load_ack_p1;

endmodule
